// File: rtl/dfdd_pkg.sv
// Shared types and helpers for the dfdd pyramid path: pixel word, coordinates,
// replicator state encoding and the replication-factor helper.
package dfdd_pkg;

  localparam int unsigned EXP_WIDTH_DEF  = 8;
  localparam int unsigned FRAC_WIDTH_DEF = 23;
  localparam int unsigned FP_WIDTH_DEF   = 1 + FRAC_WIDTH_DEF + EXP_WIDTH_DEF;

  typedef logic [FP_WIDTH_DEF-1:0] fp_t;
  typedef logic [15:0]             coord_t;

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_REPLAY = 1'b1
  } rep_state_e;

  // Replication factor F = 2^(SCALE+1)
  function automatic int unsigned scale_factor(input int unsigned scale);
    return 32'd1 << (scale + 32'd1);
  endfunction

endpackage

// File: rtl/pixel_replicator_if.sv
// Pixel stream bundle for pixel_replicator: upstream valid/ready input side and
// the coordinate-tagged, non-backpressured output side.
interface pixel_replicator_if #(
  parameter int unsigned FP_W = 32
) ();
  import dfdd_pkg::*;

  logic [FP_W-1:0] data_i;
  logic            valid_i;
  logic            ready_o;
  logic [FP_W-1:0] data_o;
  coord_t          col_o;
  coord_t          row_o;
  logic            valid_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, data_o, col_o, row_o, valid_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, data_o, col_o, row_o, valid_o
  );

endinterface

// File: rtl/line_buffer.sv
// Simple dual-port line RAM: synchronous write, registered one-cycle read.
module line_buffer #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pixel_replicator.sv
// Replicates each input pixel F times per line and each line F times, tagging
// full-resolution col/row. Optional sticky drop flag: PIXEL_REPLICATOR_DROP_FLAG_EN.
module pixel_replicator
  import dfdd_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 23,
  parameter int unsigned SCALE      = 0,
  parameter int unsigned IN_WIDTH   = 320,
  parameter int unsigned IN_HEIGHT  = 240
) (
  input  logic clk_i,
  input  logic rst_n_i,
`ifdef PIXEL_REPLICATOR_DROP_FLAG_EN
  output logic drop_o,
`endif
  pixel_replicator_if.slave bus
);

  localparam int unsigned FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH;
  localparam int unsigned F            = scale_factor(SCALE);
  localparam int unsigned LOG_F        = SCALE + 1;
  localparam int unsigned AW           = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned HW           = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned ROW_LAST     = IN_WIDTH * F - 1;

  localparam logic [0:0] S_ACCEPT = ST_ACCEPT;
  localparam logic [0:0] S_REPLAY = ST_REPLAY;

  logic [0:0]              state_q, state_d;
  logic [AW-1:0]           in_col_q, in_col_d;
  logic [HW-1:0]           in_row_q, in_row_d;
  logic [LOG_F-1:0]        hrep_q, hrep_d;
  logic [LOG_F-1:0]        vrep_q, vrep_d;
  coord_t                  out_col_q, out_col_d;
  logic                    rd_v_q, rd_v_d;
  coord_t                  rd_col_q, rd_col_d;
  coord_t                  rd_row_q, rd_row_d;
  logic [FP_WIDTH_REG-1:0] data_q, data_d;
  coord_t                  col_q, col_d;
  coord_t                  row_q, row_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;

  logic                    xfer;
  logic                    wr_en;
  logic [AW-1:0]           rd_addr;
  logic [FP_WIDTH_REG-1:0] rd_data;

  assign xfer    = bus.valid_i & ready_q;
  assign rd_addr = AW'(out_col_q >> LOG_F);

  line_buffer #(
    .DEPTH (IN_WIDTH),
    .WIDTH (FP_WIDTH_REG),
    .AW    (AW)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (in_col_q),
    .wr_data (bus.data_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_ACCEPT;
      in_col_q  <= '0;
      in_row_q  <= '0;
      hrep_q    <= '0;
      vrep_q    <= '0;
      out_col_q <= '0;
      rd_v_q    <= 1'b0;
      rd_col_q  <= '0;
      rd_row_q  <= '0;
      data_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      hrep_q    <= hrep_d;
      vrep_q    <= vrep_d;
      out_col_q <= out_col_d;
      rd_v_q    <= rd_v_d;
      rd_col_q  <= rd_col_d;
      rd_row_q  <= rd_row_d;
      data_q    <= data_d;
      col_q     <= col_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    hrep_d    = hrep_q;
    vrep_d    = vrep_q;
    out_col_d = out_col_q;
    rd_v_d    = 1'b0;
    rd_col_d  = rd_col_q;
    rd_row_d  = rd_row_q;
    data_d    = data_q;
    col_d     = col_q;
    row_d     = row_q;
    valid_d   = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        if (xfer) begin
          wr_en   = 1'b1;
          data_d  = bus.data_i;
          col_d   = 16'(in_col_q) << LOG_F;
          row_d   = 16'(in_row_q) << LOG_F;
          valid_d = 1'b1;
          hrep_d  = LOG_F'(1);
        end else if (hrep_q != '0) begin
          valid_d = 1'b1;
          col_d   = col_q + 16'd1;
          hrep_d  = hrep_q + LOG_F'(1);
          if (hrep_q == LOG_F'(F - 1)) begin
            if (in_col_q == AW'(IN_WIDTH - 1)) begin
              in_col_d  = '0;
              state_d   = S_REPLAY;
              vrep_d    = LOG_F'(1);
              out_col_d = '0;
            end else begin
              in_col_d = in_col_q + AW'(1);
            end
          end
        end
      end
      S_REPLAY: begin
        rd_v_d   = 1'b1;
        rd_col_d = out_col_q;
        rd_row_d = (16'(in_row_q) << LOG_F) | 16'(vrep_q);
        if (out_col_q == 16'(ROW_LAST)) begin
          out_col_d = '0;
          vrep_d    = vrep_q + LOG_F'(1);
          if (vrep_q == LOG_F'(F - 1)) begin
            state_d  = S_ACCEPT;
            in_row_d = (in_row_q == HW'(IN_HEIGHT - 1)) ? '0 : in_row_q + HW'(1);
          end
        end else begin
          out_col_d = out_col_q + 16'd1;
        end
      end
      default: state_d = S_ACCEPT;
    endcase

    // Replay data lands one cycle after the read is issued
    if (rd_v_q) begin
      data_d  = rd_data;
      col_d   = rd_col_q;
      row_d   = rd_row_q;
      valid_d = 1'b1;
    end

    // Hold off upstream until the replay pipeline has drained
    ready_d = (state_d == S_ACCEPT) && (hrep_d == '0) && !rd_v_d;
  end

  assign bus.ready_o = ready_q;
  assign bus.data_o  = data_q;
  assign bus.col_o   = col_q;
  assign bus.row_o   = row_q;
  assign bus.valid_o = valid_q;

`ifdef PIXEL_REPLICATOR_DROP_FLAG_EN
  logic drop_q;

  // Sticky flag for words offered while not ready
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) drop_q <= 1'b0;
    else          drop_q <= drop_q | (bus.valid_i & ~ready_q);
  end

  assign drop_o = drop_q;
`endif

endmodule

// File: doc/pixel_replicator.md
Name: pixel_replicator

Overview:
- Upsampling stage that sits directly upstream of zero_inserter in the dfdd pyramid path.
- Accepts a low-resolution FP pixel stream and replicates each pixel F = 2^(SCALE+1) times horizontally and each line F times vertically.
- Tags every output pixel with its full-resolution col/row so zero_inserter, with the same SCALE, can zero the non-aligned positions.
- Applies backpressure upstream because output volume is F² times input volume.

Parameters:
- EXP_WIDTH, 8, FP exponent width
- FRAC_WIDTH, 23, FP fraction width
- SCALE, 0, replication factor F = 2^(SCALE+1); legal values 0..2
- IN_WIDTH, 320, input pixels per line; IN_WIDTH*F must be ≤ 65536
- IN_HEIGHT, 240, input lines per frame; IN_HEIGHT*F must be ≤ 65536
- FP_WIDTH_REG, 1+FRAC_WIDTH+EXP_WIDTH, local, pixel word width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- data_i  in  FP_WIDTH_REG  input pixel
- valid_i  in  1  input pixel valid
- ready_o  out  1  block can accept data_i this cycle
- data_o  out  FP_WIDTH_REG  replicated pixel
- col_o  out  16  full-resolution column
- row_o  out  16  full-resolution row
- valid_o  out  1  output valid; no downstream backpressure

Behaviour:
- Reset (async assert, sync release): all outputs 0, state ST_ACCEPT, all counters 0. Same result when reset is asserted mid-frame; the partial frame is discarded.
- All outputs are registered. Transfer occurs when valid_i && ready_o.
- valid_i while ready_o=0 is ignored; the data is dropped.
- Counters:
  - in_col 0..IN_WIDTH-1, in_row 0..IN_HEIGHT-1
  - hrep 0..F-1 (horizontal copy index), vrep 0..F-1 (vertical copy index)
  - out_col, 16 bits
- ST_ACCEPT (vrep=0):
  - ready_o = (hrep==0).
  - On transfer at cycle t: write data_i to the line buffer at in_col. Register data_o=data_i, col_o=in_col*F, row_o=in_row*F, valid_o=1 at t+1.
  - Copies 1..F-1 follow on consecutive cycles t+2..t+F with col_o incrementing. ready_o is low during these copies.
  - Maximum input rate is 1 pixel per F cycles. Gaps on valid_i are allowed; valid_o=0 in idle cycles.
  - After the last copy of in_col=IN_WIDTH-1: go to ST_REPLAY, vrep=1.
- ST_REPLAY (ready_o=0):
  - Emit IN_WIDTH*F pixels for row_o = in_row*F+vrep.
  - Read address = out_col >> (SCALE+1). RAM has 1-cycle read latency, so the first pixel of each replay row appears 2 cycles after the row starts; after that, one pixel per cycle with no bubbles.
  - At the end of a row: vrep++. When vrep reaches F-1 and that row completes, set vrep=0 and in_row++, return to ST_ACCEPT.
  - After the last replay row of in_row=IN_HEIGHT-1, in_row wraps to 0 (next frame).
- Ordering: output pixels of a row are contiguous except for idle gaps caused by upstream valid_i gaps in ST_ACCEPT. Rows never interleave.
- Line buffer writes in ST_ACCEPT never collide with replay reads, since the states are exclusive.

Optional Feature:
- Macro PIXEL_REPLICATOR_DROP_FLAG_EN.
- Defined: adds output port drop_o (1 bit), a sticky flag set the cycle after valid_i=1 && ready_o=0. Cleared only by reset; reset value 0.
- Undefined: port absent, drops are silent.

Decomposition:
- Shared package dfdd_pkg:
  - fp_t typedef sized FP_WIDTH_REG
  - coord_t (16-bit) typedef
  - replicator state enum {ST_ACCEPT, ST_REPLAY}
  - function scale_factor(SCALE) returning F
- One sub-module, line_buffer: simple dual-port RAM, depth IN_WIDTH, width FP_WIDTH_REG, synchronous write, registered 1-cycle read.

Test Plan:
- Basic replication: SCALE=0, IN_WIDTH=4, IN_HEIGHT=2. Send A,B,C,D then E,F,G,H.
  - Rows 0–1: AABBCCDD at col 0..7, row 0 then row 1.
  - Rows 2–3: EEFFGGHH at row 2 then row 3. 32 valid_o total.
- Wider factor: SCALE=2 (F=8), IN_WIDTH=2, IN_HEIGHT=1, pixels P,Q.
  - Each of rows 0..7 is 8×P then 8×Q, col 0..15. 128 valid_o.
  - ready_o is high for exactly 1 cycle per 8 while accepting.
- Backpressure: hold valid_i=1 continuously with SCALE=0.
  - Only every 2nd word is accepted in ST_ACCEPT; none during ST_REPLAY.
  - With PIXEL_REPLICATOR_DROP_FLAG_EN, drop_o=1 after the first refused word.
- Idle gaps: valid_i pulses every 5 cycles. Output values and coordinates match the basic replication test, with valid_o gaps only in the even output rows (vrep=0).
- Reset mid-replay: deassert rst_n_i during row 1 of the basic replication test.
  - Outputs and drop_o go 0 immediately.
  - A new frame then starts at row 0, col 0.
- Frame wrap: run 2 frames back-to-back. The second frame begins at row_o=0, col_o=0 with no extra latency beyond the 1-cycle input-to-output delay.
